// File: rtl/icache_axi_rd_bridge_if.sv
// rtl/icache_axi_rd_bridge_if.sv - cache read-request / AXI4 read-channel bundle for icache_axi_rd_bridge
interface icache_axi_rd_bridge_if;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        rd_err;

  modport master (
    input  rd_req, rd_type, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    output rd_rdy, ret_valid, ret_last, ret_data, arid, araddr, arlen, arsize,
           arburst, arvalid, rready, rd_err
  );

  modport slave (
    output rd_req, rd_type, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    input  rd_rdy, ret_valid, ret_last, ret_data, arid, araddr, arlen, arsize,
           arburst, arvalid, rready, rd_err
  );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// rtl/icache_axi_rd_bridge.sv - single-outstanding AXI4 read master behind the icache; ICACHE_AXI_RCHK_EN enables R-channel checking
module icache_axi_rd_bridge #(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input logic                    clock,
  input logic                    reset,
  icache_axi_rd_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state;
  logic        rd_rdy_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic        ret_valid_q;
  logic        ret_last_q;
  logic [31:0] ret_data_q;
  logic        beat_acc;
  logic        unused_ok;

  // rready_q is high exactly while in DATA, so this is the R handshake.
  assign beat_acc = rready_q && bus.rvalid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rd_rdy_q  <= 1'b1;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rd_req) begin
            araddr_q  <= bus.rd_addr;
            arlen_q   <= (bus.rd_type == 3'b100) ? 8'd3 : 8'd0;
            rd_rdy_q  <= 1'b0;
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (bus.rvalid && bus.rlast) begin
            rready_q <= 1'b0;
            rd_rdy_q <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rd_rdy_q  <= 1'b1;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  // Registered return path; the cache never stalls it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= 32'd0;
    end else begin
      ret_valid_q <= beat_acc;
      ret_last_q  <= beat_acc && bus.rlast;
      if (beat_acc) begin
        ret_data_q <= bus.rdata;
      end
    end
  end

`ifdef ICACHE_AXI_RCHK_EN
  logic [1:0] beat_cnt;
  logic       rd_err_q;

  // A beat is in error if its response is bad, or if rlast disagrees with
  // whether this beat index is the final one arlen promised.
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_cnt <= 2'd0;
      rd_err_q <= 1'b0;
    end else begin
      if (state == ADDR && bus.arready) begin
        beat_cnt <= 2'd0;
      end else if (beat_acc) begin
        beat_cnt <= beat_cnt + 2'd1;
      end
      if (beat_acc && ((bus.rresp != 2'b00) ||
                       (bus.rlast != (beat_cnt == arlen_q[1:0])))) begin
        rd_err_q <= 1'b1;
      end
    end
  end

  assign bus.rd_err = rd_err_q;
`else
  assign bus.rd_err = 1'b0;
`endif

  assign unused_ok = ^{bus.rid, bus.rresp};

  assign bus.rd_rdy    = rd_rdy_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.araddr    = araddr_q;
  assign bus.arlen     = arlen_q;
  assign bus.arid      = ARID_VAL;
  assign bus.arsize    = 3'b010;
  assign bus.arburst   = 2'b01;
  assign bus.rready    = rready_q;
  assign bus.ret_valid = ret_valid_q;
  assign bus.ret_last  = ret_last_q;
  assign bus.ret_data  = ret_data_q;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// tb/tb_icache_axi_rd_bridge.sv - scoreboard bench for icache_axi_rd_bridge, random AR/R timing
module tb_icache_axi_rd_bridge;
  localparam logic [3:0] ARID = 4'd5;
`ifdef ICACHE_AXI_RCHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  icache_axi_rd_bridge_if bus();

  icache_axi_rd_bridge #(.ARID_VAL(ARID)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } ret_t;

  ret_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_rv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Each beat the bench presents in DATA must reappear exactly one cycle later.
  always @(posedge clock) exp_rv <= reset ? 1'b0 : bus.rvalid;

  always @(negedge clock) begin
    ret_t e;
    if (bus.ret_valid === 1'b1 || exp_rv === 1'b1)
      check("ret_valid_timing", 32'(bus.ret_valid), 32'(exp_rv));
    if (bus.ret_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("ret_unexpected_word", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("ret_data", bus.ret_data, e.data);
        check("ret_last", 32'(bus.ret_last), 32'(e.last));
        if (e.last) check("rd_rdy_with_last", 32'(bus.rd_rdy), 32'd1);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 50 && bus.rd_rdy !== 1'b1; i++) begin
      @(posedge clock); #1;
    end
    check("rd_rdy_idle", 32'(bus.rd_rdy), 32'd1);
  endtask

  // One full transaction: nbeats=0 means the beat count the request type implies.
  task automatic issue(input logic [2:0] t, input logic [31:0] a, input int ar_dly,
                       input int nbeats, input int bad_beat, input int max_gap,
                       input int gap_at, input int gap_len, input bit fixed);
    int          words;
    int          n;
    int          gap;
    logic [31:0] d[$];
    ret_t        r;
    words = (t == 3'b100) ? 4 : 1;
    n = (nbeats == 0) ? words : nbeats;
    wait_idle();
    bus.rd_req  = 1'b1;
    bus.rd_type = t;
    bus.rd_addr = a;
    @(posedge clock); #1;
    bus.rd_req  = 1'b0;
    bus.rd_type = 3'($urandom);
    bus.rd_addr = $urandom;
    for (int b = 0; b < n; b++) begin
      r.data = fixed ? 32'(8'h11 * (b + 1)) : $urandom;
      r.last = (b == n - 1);
      d.push_back(r.data);
      exp_q.push_back(r);
    end
    for (int i = 0; i < ar_dly; i++) begin
      @(negedge clock);
      check("arvalid_hold", 32'(bus.arvalid), 32'd1);
      check("araddr_hold", bus.araddr, a);
      @(posedge clock); #1;
    end
    bus.arready = 1'b1;
    @(negedge clock);
    check("arvalid", 32'(bus.arvalid), 32'd1);
    check("araddr", bus.araddr, a);
    check("arlen", 32'(bus.arlen), 32'(words - 1));
    check("arsize_arburst_arid", 32'({bus.arsize, bus.arburst, bus.arid}), 32'({3'b010, 2'b01, ARID}));
    check("rready_in_addr", 32'(bus.rready), 32'd0);
    @(posedge clock); #1;
    bus.arready = 1'b0;
    for (int b = 0; b < n; b++) begin
      gap = (b == gap_at) ? gap_len : int'($urandom_range(max_gap, 0));
      repeat (gap) begin
        @(posedge clock); #1;
      end
      bus.rvalid = 1'b1;
      bus.rdata  = d[b];
      bus.rlast  = (b == n - 1);
      bus.rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
      bus.rid    = 4'($urandom);
      @(negedge clock);
      check("rready_beat", 32'(bus.rready), 32'd1);
      check("rd_rdy_busy", 32'(bus.rd_rdy), 32'd0);
      @(posedge clock); #1;
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      bus.rresp  = 2'b00;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 32'({bus.arvalid, bus.rready, bus.ret_valid, bus.ret_last, bus.rd_err}), 32'd0);
    check({tag, "_ret_data"}, bus.ret_data, 32'd0);
    check({tag, "_araddr"}, bus.araddr, 32'd0);
    check({tag, "_arlen"}, 32'(bus.arlen), 32'd0);
  endtask

  initial begin
    logic [2:0]  t;
    logic [31:0] a;
    bus.rd_req = 1'b0; bus.rd_type = 3'b000; bus.rd_addr = 32'd0;
    bus.arready = 1'b0; bus.rid = 4'd0; bus.rdata = 32'd0;
    bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rvalid = 1'b0;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset");
    check("reset_rd_rdy", 32'(bus.rd_rdy), 32'd1);
    @(posedge clock); #1;

    issue(3'b100, 32'h1C00_00F0, 0, 0, -1, 0, -1, 0, 1'b1);
    issue(3'b010, 32'h8000_0004, 3, 0, -1, 0, -1, 0, 1'b0);
    issue(3'b100, 32'h0000_1230, 1, 0, -1, 0, 3, 2, 1'b0);

    for (int k = 0; k < 20; k++) begin
      t = 3'($urandom);
      if (k % 3 == 0) t = 3'b100;
      a = (t == 3'b100) ? ($urandom & 32'hFFFF_FFF0) : ($urandom & 32'hFFFF_FFFC);
      issue(t, a, int'($urandom_range(3, 0)), 0, -1, 2, -1, 0, 1'b0);
    end
    repeat (2) @(posedge clock); #1;
    check("rd_err_clean", 32'(bus.rd_err), 32'd0);

    issue(3'b100, 32'h0000_4000, 0, 0, 1, 0, -1, 0, 1'b0);
    repeat (2) @(posedge clock); #1;
    check("rd_err_rresp", 32'(bus.rd_err), 32'(EXP_ERR));
    issue(3'b010, 32'h0000_4010, 0, 0, -1, 1, -1, 0, 1'b0);
    repeat (2) @(posedge clock); #1;
    check("rd_err_sticky", 32'(bus.rd_err), 32'(EXP_ERR));

    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rd_err_cleared", 32'(bus.rd_err), 32'd0);
    @(posedge clock); #1;
    issue(3'b010, 32'h0000_5000, 1, 2, -1, 0, -1, 0, 1'b0);
    repeat (2) @(posedge clock); #1;
    check("rd_err_extra_beat", 32'(bus.rd_err), 32'(EXP_ERR));

    // Abandon a line read after two beats: only those two words may return.
    wait_idle();
    bus.rd_req = 1'b1; bus.rd_type = 3'b100; bus.rd_addr = 32'h0000_6000;
    @(posedge clock); #1;
    bus.rd_req = 1'b0;
    bus.arready = 1'b1;
    @(posedge clock); #1;
    bus.arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      ret_t r;
      r.data = $urandom;
      r.last = 1'b0;
      exp_q.push_back(r);
      bus.rvalid = 1'b1; bus.rdata = r.data; bus.rlast = 1'b0;
      @(posedge clock); #1;
    end
    bus.rvalid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check_reset_outputs("midtxn_reset");
    #1 reset = 1'b0;
    @(negedge clock);
    check("post_reset_rd_rdy", 32'(bus.rd_rdy), 32'd1);
    check("post_reset_quiet", 32'(bus.ret_valid), 32'd0);
    @(posedge clock); #1;
    issue(3'b100, 32'h0000_7000, 2, 0, -1, 1, -1, 0, 1'b0);

    repeat (4) @(posedge clock); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_axi_rd_bridge.md
# icache_axi_rd_bridge

Read-only AXI4 master that sits directly downstream of the instruction cache. It accepts one refill or uncached read request at a time over the cache's `rd_req`/`rd_rdy` handshake, issues a single AR transaction, and streams the returned 32-bit beats back over `ret_valid`/`ret_data`/`ret_last` through a registered return path. One transaction is outstanding at a time, and the block never drives write channels.

## Interface
- `ARID_VAL`, default 4'd0: constant value driven on `arid`.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rd_req`  in  1  cache read request; accepted when `rd_req && rd_rdy`.
- `rd_type`  in  3  3'b100 = 4-word line; 3'b010 = single word; any other encoding is treated as single word.
- `rd_addr`  in  32  byte address; line requests are 16-byte aligned by the cache.
- `rd_rdy`  out  1  bridge idle, can accept a request.
- `ret_valid`  out  1  one returned word valid this cycle.
- `ret_last`  out  1  qualifies the final word of the transaction.
- `ret_data`  out  32  returned word.
- `arid`  out  4  `ARID_VAL`.
- `araddr`  out  32  latched `rd_addr`.
- `arlen`  out  8  8'd3 for a line, 8'd0 for a word.
- `arsize`  out  3  always 3'b010.
- `arburst`  out  2  always 2'b01 (INCR).
- `arvalid`  out  1  AR valid.
- `arready`  in  1  AR ready.
- `rid`  in  4  ignored.
- `rdata`  in  32  R data.
- `rresp`  in  2  R response.
- `rlast`  in  1  R last.
- `rvalid`  in  1  R valid.
- `rready`  out  1  R ready.
- `rd_err`  out  1  sticky error flag; see Configuration.

## Operation
- **FSM states:** IDLE, ADDR, DATA.
  - IDLE: `rd_rdy`=1. On `rd_req` the block latches `rd_addr` and `rd_type` into request registers, computes `arlen` from type, and goes to ADDR.
  - ADDR: `arvalid`=1, with AR fields held stable from the request registers. `arvalid` does not depend on `arready`. On `arready` the block goes to DATA.
  - DATA: `rready`=1. Each `rvalid` beat is accepted. The beat counter (2 bits, cleared on AR handshake) increments per beat. On an accepted beat with `rlast`=1 the block goes to IDLE.
- **Return path:** registered. An accepted beat in cycle U produces `ret_valid`=1, `ret_data`=`rdata`, and `ret_last`=`rlast` in cycle U+1. `ret_valid` is 0 in every cycle where no beat was accepted in the previous cycle. The cache is required to absorb every `ret_valid` pulse, so there is no backpressure toward the cache.
- **Termination:** a transaction always ends on `rlast`. The beat count only feeds error checking.
- **Reset values:** state=IDLE; `arvalid`=0, `rready`=0, `ret_valid`=0, `ret_last`=0, `ret_data`=0, `araddr`=0, `arlen`=0, `rd_err`=0. `rd_rdy` is 1 from the first cycle after reset deasserts.
- **Reset mid-transaction:** the transaction is abandoned and no `ret_valid` is produced. The AXI slave shares this reset.
- **`rd_req` outside IDLE:** ignored. The cache holds it until `rd_rdy`.

## Timing
- **Request accept:** cycle T. `arvalid` rises at T+1.
- **AR handshake:** `arvalid && arready` at cycle A. `rready` rises at A+1.
- **Minimum request-to-first-word latency:** 4 cycles (T accept; T+1 AR handshake; T+2 beat accepted; T+3 `ret_valid`).
- **Back-to-back requests:** last beat accepted at U gives state IDLE and `rd_rdy`=1 at U+1, the same cycle as the last `ret_valid`. The next request can be accepted at U+1.
- **R-channel stalls:** `rvalid` gaps between beats produce gaps in `ret_valid`, and word order is preserved.

## Configuration
- **`ICACHE_AXI_RCHK_EN` defined:** in DATA, `rd_err` is set and held until reset when any of the following occurs:
  - an accepted beat has `rresp`≠2'b00;
  - `rlast`=1 arrives with beat count ≠ `arlen[1:0]`;
  - beat count reaches `arlen[1:0]` without `rlast`.

  Data is still forwarded unchanged and termination is still on `rlast`.
- **Not defined:** `rresp` and the beat count are not examined, and `rd_err` is tied to 0.

## Test plan
- Line read at 0x1C000_0F0 (`rd_type`=3'b100), `arready` immediate, R beats 0x11,0x22,0x33,0x44 contiguous: `araddr`=0x1C0000F0, `arlen`=3, `arburst`=01; four consecutive `ret_valid` with data in order; `ret_last` only on 0x44; `rd_rdy`=1 in the same cycle as the 0x44 word.
- Word read (`rd_type`=3'b010) at 0x8000_0004, `arready` delayed 3 cycles: `arvalid` and `araddr` stable for all 4 cycles; `arlen`=0; single `ret_valid` with `ret_last`=1.
- Line read with `rvalid` low for 2 cycles between beats 2 and 3: `ret_valid` gap mirrors the stall, order preserved, `rd_rdy` stays 0 until after `rlast`.
- Reset asserted during DATA after 2 beats: next cycle all outputs are at reset values with no further `ret_valid`; a new request after reset completes normally.
- With `ICACHE_AXI_RCHK_EN`: line read with beat 1 `rresp`=2'b10 leaves `rd_err`=1 permanently with all four words forwarded; a word read with `rlast` on a second beat also gives `rd_err`=1. Without the macro, the same stimulus gives `rd_err`=0.
